mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Single-port memory access controller for the multicycle MIPS core. Arbitrates between the instruction-fetch requester and the data load/store requester. Sequences each granted access through a request/ready handshake with the unified memory, and generates word-aligned addresses, byte enables and lane-replicated store data. Load data is returned as the raw 32-bit word; byte/half extraction and sign extension stay in the downstream load-extract stage, which receives d_op and d_addr[1:0] unchanged.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT_CYC, 64, max cycles in ACCESS before abort (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch byte address
if_ack  out  1  one-cycle completion pulse for fetch
if_rdata  out  32  fetched word, valid with if_ack
d_req  in  1  data request, held until d_ack
d_op  in  6  MIPS opcode: LW 100011, LH 100001, LHU 100101, LB 100000, LBU 100100, SW 101011, SH 101001, SB 101000
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-justified
d_ack  out  1  one-cycle completion pulse for data
d_rdata  out  32  raw memory word, valid with d_ack on loads
d_err  out  1  valid with d_ack; 1 = misaligned, illegal op or timeout
mem_en  out  1  memory request
mem_we  out  1  write strobe
mem_be  out  4  byte enables; bit i = byte lane [8i+7:8i]
mem_addr  out  ADDR_W  word address, with bits [1:0] = 00
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, one cycle

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All outputs are 0: if_ack, d_ack, d_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata. A reset asserted mid-ACCESS abandons the transaction and issues no ack.
- States are IDLE, ACCESS and DONE.
- IDLE: on a clock edge with d_req=1 or if_req=1, the controller grants one requester and registers its op, address and data.
  - Data has fixed priority over fetch when both are asserted.
  - Misaligned or illegal data request: go to DONE with err=1 and no memory cycle.
    - Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
    - Illegal means any opcode not listed above.
  - Otherwise go to ACCESS.
- ACCESS: mem_en=1 with registered mem_addr, mem_we, mem_be and mem_wdata, all held stable.
  - Stay in ACCESS while mem_ready=0.
  - On mem_ready=1: capture mem_rdata and go to DONE.
- DONE: pulse the granted requester's ack for exactly one cycle (d_err is meaningful only with d_ack; if_ack never carries an error). Return to IDLE. A new grant occurs no earlier than the cycle after DONE, so minimum spacing is 3 cycles per access.
- Latency: with mem_ready returned in the first ACCESS cycle, ack asserts 2 cycles after the request edge.
- Byte enables:
  - Fetch and all loads: 1111.
  - SW: 1111.
  - SH: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - SB: one-hot 1<<addr[1:0].
- Store data: SW uses the word as-is. SH replicates {2{d_wdata[15:0]}}. SB replicates {4{d_wdata[7:0]}}. For loads and fetches, mem_wdata is 0.
- mem_we=1 only for SW/SH/SB.
- mem_ready is ignored outside ACCESS.
- Requester dropping req before ack: the access still completes and the ack is still pulsed.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYC-1 with mem_ready still 0: drop mem_en, go to DONE, and ack with d_err=1 for data. For fetch, if_ack pulses with if_rdata=0.
  - The counter resets asynchronously with rst_n.
- Not defined: no counter; ACCESS waits for mem_ready indefinitely.

Test Plan:
- Reset: rst_n=0 mid-ACCESS → all outputs 0 immediately; after release, no spurious ack.
- LW at 0x0000_0010, mem_ready in the first ACCESS cycle returning 0xDEADBEEF → mem_addr=0x10, mem_be=1111, mem_we=0; d_ack+d_rdata=0xDEADBEEF 2 cycles after the request edge, d_err=0.
- SB at 0x0000_0023 with d_wdata=0x000000A5 → mem_addr=0x20, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1. SH at 0x22 → mem_be=1100, mem_wdata={2{low half}}.
- Misaligned LH at 0x0000_0005 → no mem_en cycle; d_ack with d_err=1 in the cycle after the request edge.
- if_req and d_req asserted on the same edge → data served first. if_ack follows, with the fetch grant no earlier than the cycle after d_ack. mem_ready delayed 5 cycles → mem_en held stable for 6 cycles.
- MEM_TIMEOUT_EN with TIMEOUT_CYC=8 and mem_ready tied 0 → mem_en high for 8 cycles, then d_ack with d_err=1. Without the macro → still waiting after 100 cycles.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Requester-side bus of mem_access_ctrl: instruction-fetch and data load/store handshakes.
// master = core requesters, slave = the access controller.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic [5:0]        d_op;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;

  modport master (
    output if_req, if_addr, d_req, d_op, d_addr, d_wdata,
    input  if_ack, if_rdata, d_ack, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_op, d_addr, d_wdata,
    output if_ack, if_rdata, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-port memory access controller: arbitrates fetch vs data, sequences IDLE/ACCESS/DONE.
// Optional MEM_TIMEOUT_EN aborts an ACCESS that has waited TIMEOUT_CYC cycles for mem_ready.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  req_bus,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_ready
);

  if (TIMEOUT_CYC < 2 || ADDR_W < 3) begin : g_param_check
    $error("mem_access_ctrl: TIMEOUT_CYC must be >= 2 and ADDR_W >= 3");
  end

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            r_state;
  logic              r_grant_d;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_if_ack;
  logic [31:0]       r_if_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [31:0]       r_d_rdata;

  logic [1:0]  w_d_lo;
  logic        w_d_legal;
  logic        w_d_misalign;
  logic        w_d_store;
  logic [3:0]  w_d_be;
  logic [31:0] w_d_wdata;
  logic        w_timeout;

  assign w_d_lo = req_bus.d_addr[1:0];

  // Opcode decode: legality, alignment, lane enables and replicated store data.
  always_comb begin
    w_d_legal    = 1'b1;
    w_d_misalign = 1'b0;
    w_d_store    = 1'b0;
    w_d_be       = 4'b1111;
    w_d_wdata    = '0;
    case (req_bus.d_op)
      OpLw: begin
        w_d_misalign = |w_d_lo;
      end
      OpLh, OpLhu: begin
        w_d_misalign = w_d_lo[0];
      end
      OpLb, OpLbu: begin
        w_d_misalign = 1'b0;
      end
      OpSw: begin
        w_d_store    = 1'b1;
        w_d_misalign = |w_d_lo;
        w_d_wdata    = req_bus.d_wdata;
      end
      OpSh: begin
        w_d_store    = 1'b1;
        w_d_misalign = w_d_lo[0];
        w_d_be       = w_d_lo[1] ? 4'b1100 : 4'b0011;
        w_d_wdata    = {2{req_bus.d_wdata[15:0]}};
      end
      OpSb: begin
        w_d_store = 1'b1;
        w_d_be    = 4'b0001 << w_d_lo;
        w_d_wdata = {4{req_bus.d_wdata[7:0]}};
      end
      default: begin
        w_d_legal = 1'b0;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

  logic [CntW-1:0] r_tmo_cnt;

  assign w_timeout = !i_mem_ready && (r_tmo_cnt == CntW'(TIMEOUT_CYC - 1));

  // Held at zero outside ACCESS so every access starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state != StAccess) begin
      r_tmo_cnt <= '0;
    end else if (!w_timeout) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_grant_d   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      // Acks are single-cycle: raised on entry to DONE, dropped on the next edge.
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_bus.d_req) begin
            r_grant_d <= 1'b1;
            if (!w_d_legal || w_d_misalign) begin
              r_state   <= StDone;
              r_d_ack   <= 1'b1;
              r_d_err   <= 1'b1;
              r_d_rdata <= '0;
            end else begin
              r_state     <= StAccess;
              r_mem_en    <= 1'b1;
              r_mem_we    <= w_d_store;
              r_mem_be    <= w_d_be;
              r_mem_addr  <= {req_bus.d_addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= w_d_wdata;
            end
          end else if (req_bus.if_req) begin
            r_grant_d   <= 1'b0;
            r_state     <= StAccess;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b1111;
            r_mem_addr  <= req_bus.if_addr & ~ADDR_W'(3);
            r_mem_wdata <= '0;
          end
        end
        StAccess: begin
          if (i_mem_ready || w_timeout) begin
            r_state     <= StDone;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_grant_d) begin
              r_d_ack   <= 1'b1;
              r_d_err   <= w_timeout;
              r_d_rdata <= w_timeout ? 32'h0 : i_mem_rdata;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_timeout ? 32'h0 : i_mem_rdata;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_d_err <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  assign req_bus.if_ack   = r_if_ack;
  assign req_bus.if_rdata = r_if_rdata;
  assign req_bus.d_ack    = r_d_ack;
  assign req_bus.d_rdata  = r_d_rdata;
  assign req_bus.d_err    = r_d_err;

  a_en_matches_state : assert property (@(posedge clk) disable iff (!rst_n)
    r_mem_en == (r_state == StAccess));

  a_single_ack : assert property (@(posedge clk) disable iff (!rst_n)
    !(r_if_ack && r_d_ack));

endmodule
